uart_rx_fifo_param: RTL and testbench

Parametrised receive FIFO for the UART RX path. It sits between the RX deserialiser and the bus-side register interface, and buffers characters together with a per-entry status field (frame/parity/break). Over the previous fixed 16x8 RX FIFO it adds:
- configurable data width and depth;
- a programmable trigger level;
- a sticky overrun flag;
- a synchronous flush;
- an erroneous-entry counter;
- a character-timeout indication.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_ram.sv | 24 ++
 rtl/uart_rx_fifo_param.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo_param.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART RX path: status bit positions and default status width.
package uart_pkg;

   localparam int UART_STATUS_WIDTH = 3;

   localparam int STATUS_FRAME  = 0;
   localparam int STATUS_PARITY = 1;
   localparam int STATUS_BREAK  = 2;

endpackage

// File: rtl/uart_fifo_ram.sv
// Entry storage for the RX FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_ram #(
   parameter int WIDTH     = 11,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clock,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo_param.sv
// RX character FIFO with per-entry status, trigger level, sticky overrun, flush, error tracking and timeout.
// Head is visible combinationally; pops and pushes take effect at the next edge; writes while full are dropped and flagged.
module uart_rx_fifo_param
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int DEPTH_LOG2     = 4,
   parameter int STATUS_WIDTH   = UART_STATUS_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    fifoWe,
   input  logic [DATA_WIDTH-1:0]   dataIn,
   input  logic [STATUS_WIDTH-1:0] statusIn,
   input  logic                    fifoRe,
   input  logic                    flush,
   input  logic                    clearOverrun,
   input  logic [DEPTH_LOG2:0]     triggerLevel,
   output logic [DATA_WIDTH-1:0]   dataOut,
   output logic [STATUS_WIDTH-1:0] statusOut,
   output logic                    fifoEmpty,
   output logic                    fifoFull,
   output logic [DEPTH_LOG2:0]     nrOfEntries,
   output logic                    levelReached,
   output logic                    overrun,
   output logic                    errorPresent,
   output logic                    timeout
);

   localparam int CW = DEPTH_LOG2 + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int EW = DATA_WIDTH + STATUS_WIDTH;
   localparam logic [CW-1:0] DEPTH_C = CW'(2**DEPTH_LOG2);
   localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYCLES);

   logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]           count, count_nxt;
   logic [CW-1:0]           err_count, err_nxt;
   logic [TW-1:0]           idle_cnt;
   logic                    empty_q, full_q, overrun_q;
   logic                    rd_acc, wr_acc, ram_we;
   logic [EW-1:0]           head;
   logic [STATUS_WIDTH-1:0] head_status;

   // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
   always_comb begin
      rd_acc      = fifoRe & ~empty_q;
      wr_acc      = fifoWe & (~full_q | rd_acc);
      ram_we      = wr_acc & reset & ~flush;
      head_status = head[DATA_WIDTH +: STATUS_WIDTH];
      count_nxt   = count + CW'(wr_acc) - CW'(rd_acc);
      err_nxt     = err_count + CW'(wr_acc & (|statusIn)) - CW'(rd_acc & (|head_status));
   end

   uart_fifo_ram #(
      .WIDTH     (EW),
      .ADDR_BITS (DEPTH_LOG2)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata ({statusIn, dataIn}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         overrun_q <= 1'b0;
         err_count <= '0;
         idle_cnt  <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         err_count <= '0;
         idle_cnt  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count     <= count_nxt;
         empty_q   <= (count_nxt == '0);
         full_q    <= (count_nxt == DEPTH_C);
         err_count <= err_nxt;
         // Setting wins over a coincident clear so no overrun event is lost.
         if (fifoWe & full_q & ~rd_acc) begin
            overrun_q <= 1'b1;
         end else if (clearOverrun) begin
            overrun_q <= 1'b0;
         end
         if (wr_acc | rd_acc | empty_q) begin
            idle_cnt <= '0;
         end else if (idle_cnt != TMAX) begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

   assign dataOut      = head[DATA_WIDTH-1:0];
   assign statusOut    = empty_q ? '0 : head_status;
   assign fifoEmpty    = empty_q;
   assign fifoFull     = full_q;
   assign nrOfEntries  = count;
   assign levelReached = (triggerLevel != '0) && (count >= triggerLevel);
   assign overrun      = overrun_q;
   assign errorPresent = (err_count != '0);
   assign timeout      = (idle_cnt == TMAX) & ~empty_q;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: directed scenarios followed by random traffic, checked by a queue model and scoreboard.
module tb_uart_rx_fifo_param;

   localparam int DEPTH = 16;
   localparam int TMO   = 64;

   typedef struct packed {
      logic [2:0] st;
      logic [7:0] d;
   } ent_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       fifoWe = 1'b0;
   logic [7:0] dataIn = '0;
   logic [2:0] statusIn = '0;
   logic       fifoRe = 1'b0;
   logic       flush = 1'b0;
   logic       clearOverrun = 1'b0;
   logic [4:0] triggerLevel = '0;
   logic [7:0] dataOut;
   logic [2:0] statusOut;
   logic       fifoEmpty, fifoFull, levelReached, overrun, errorPresent, timeout;
   logic [4:0] nrOfEntries;

   uart_rx_fifo_param dut (
      .clock        (clock),
      .reset        (reset),
      .fifoWe       (fifoWe),
      .dataIn       (dataIn),
      .statusIn     (statusIn),
      .fifoRe       (fifoRe),
      .flush        (flush),
      .clearOverrun (clearOverrun),
      .triggerLevel (triggerLevel),
      .dataOut      (dataOut),
      .statusOut    (statusOut),
      .fifoEmpty    (fifoEmpty),
      .fifoFull     (fifoFull),
      .nrOfEntries  (nrOfEntries),
      .levelReached (levelReached),
      .overrun      (overrun),
      .errorPresent (errorPresent),
      .timeout      (timeout)
   );

   always #5 clock = ~clock;

   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   ent_t mq[$];
   ent_t sb[$];
   bit   m_ovr = 1'b0;
   int   cyc = 0;
   int   last_quiet = 0;
   bit   m_ra, m_wa, m_was_empty;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_err();
      foreach (mq[i]) if (mq[i].st != 0) return 1'b1;
      return 1'b0;
   endfunction

   // Reference model: a queue of stored entries plus the cycle of the last "quiet-breaking" event.
   always @(posedge clock) begin
      cyc++;
      if (!reset || flush) begin
         if (!reset) m_ovr = 1'b0;
         mq.delete();
         sb.delete();
         last_quiet = cyc;
      end else begin
         m_was_empty = (mq.size() == 0);
         m_ra = fifoRe && !m_was_empty;
         m_wa = fifoWe && (mq.size() < DEPTH || m_ra);
         if (fifoWe && mq.size() == DEPTH && !m_ra) m_ovr = 1'b1;
         else if (clearOverrun) m_ovr = 1'b0;
         if (m_ra) void'(mq.pop_front());
         if (m_wa) begin
            mq.push_back('{st: statusIn, d: dataIn});
            sb.push_back('{st: statusIn, d: dataIn});
         end
         if (m_ra || m_wa || m_was_empty) last_quiet = cyc;
      end
   end

   // Monitor: pops the scoreboard on every real read and checks all flags against the model.
   always @(negedge clock) begin
      ent_t e;
      if (mon_en) begin
         if (reset && !flush && fifoRe && !fifoEmpty) begin
            if (sb.size() == 0) begin
               chk("pop_underflow", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("pop_data", 32'(dataOut), 32'(e.d));
               chk("pop_status", 32'(statusOut), 32'(e.st));
            end
         end
         chk("empty", 32'(fifoEmpty), 32'(mq.size() == 0));
         chk("full", 32'(fifoFull), 32'(mq.size() == DEPTH));
         chk("entries", 32'(nrOfEntries), 32'(mq.size()));
         chk("overrun", 32'(overrun), 32'(m_ovr));
         chk("error_present", 32'(errorPresent), 32'(model_err()));
         chk("level", 32'(levelReached),
             32'(triggerLevel != 0 && mq.size() >= int'(triggerLevel)));
         chk("timeout", 32'(timeout), 32'(mq.size() != 0 && (cyc - last_quiet) >= TMO));
         if (mq.size() == 0) chk("status_empty", 32'(statusOut), 32'd0);
      end
   end

   task automatic step(input bit we, input bit re, input logic [7:0] d, input logic [2:0] s);
      fifoWe   = we;
      fifoRe   = re;
      dataIn   = d;
      statusIn = s;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int mode;
      // reset and reset state
      repeat (3) step(0, 0, 8'h00, 3'd0);
      reset = 1'b1;
      chk("rst_empty", 32'(fifoEmpty), 32'd1);
      chk("rst_full", 32'(fifoFull), 32'd0);
      chk("rst_entries", 32'(nrOfEntries), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      mon_en = 1'b1;

      // fill, overflow, drain in order, clear overrun
      for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h41 + i), 3'd0);
      chk("fill_full", 32'(fifoFull), 32'd1);
      chk("fill_entries", 32'(nrOfEntries), 32'd16);
      step(1, 0, 8'h99, 3'd0);
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_entries", 32'(nrOfEntries), 32'd16);
      for (int i = 0; i < 16; i++) begin
         chk("drain_head", 32'(dataOut), 32'(8'h41 + i));
         step(0, 1, 8'h00, 3'd0);
      end
      chk("drain_empty", 32'(fifoEmpty), 32'd1);
      clearOverrun = 1'b1;
      step(0, 0, 8'h00, 3'd0);
      clearOverrun = 1'b0;
      chk("ovr_clear", 32'(overrun), 32'd0);

      // simultaneous read/write while full across pointer wrap
      for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 3'd0);
      for (int i = 0; i < 20; i++) step(1, 1, 8'(16 + i), 3'd0);
      chk("rw_full_entries", 32'(nrOfEntries), 32'd16);
      chk("rw_full_overrun", 32'(overrun), 32'd0);
      chk("rw_full_head", 32'(dataOut), 32'd20);
      for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 3'd0);

      // read+write on empty: only the write happens
      step(1, 1, 8'h5A, 3'd0);
      chk("empty_rw_entries", 32'(nrOfEntries), 32'd1);
      chk("empty_rw_data", 32'(dataOut), 32'h5A);
      step(0, 1, 8'h00, 3'd0);

      // error tracking
      step(1, 0, 8'h01, 3'd0);
      step(1, 0, 8'h02, 3'b010);
      step(1, 0, 8'h03, 3'd0);
      chk("err_present", 32'(errorPresent), 32'd1);
      chk("err_head0", 32'(statusOut), 32'd0);
      step(0, 1, 8'h00, 3'd0);
      chk("err_head1", 32'(statusOut), 32'b010);
      step(0, 1, 8'h00, 3'd0);
      chk("err_head2", 32'(statusOut), 32'd0);
      chk("err_cleared", 32'(errorPresent), 32'd0);
      step(0, 1, 8'h00, 3'd0);

      // trigger level and timeout
      triggerLevel = 5'd4;
      for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h60 + i), 3'd0);
      chk("level_3", 32'(levelReached), 32'd0);
      step(1, 0, 8'h63, 3'd0);
      chk("level_4", 32'(levelReached), 32'd1);
      repeat (TMO - 1) step(0, 0, 8'h00, 3'd0);
      chk("timeout_63", 32'(timeout), 32'd0);
      step(0, 0, 8'h00, 3'd0);
      chk("timeout_64", 32'(timeout), 32'd1);
      step(0, 1, 8'h00, 3'd0);
      chk("timeout_after_read", 32'(timeout), 32'd0);
      triggerLevel = 5'd0;
      step(1, 0, 8'h70, 3'd0);
      chk("level_off", 32'(levelReached), 32'd0);

      // flush keeps overrun; reset clears it and ignores a concurrent write
      while (!fifoFull) step(1, 0, 8'($urandom), 3'd0);
      step(1, 0, 8'hEE, 3'd0);
      repeat (11) step(0, 1, 8'h00, 3'd0);
      chk("pre_flush_entries", 32'(nrOfEntries), 32'd5);
      flush = 1'b1;
      step(1, 1, 8'h11, 3'd0);
      flush = 1'b0;
      chk("flush_entries", 32'(nrOfEntries), 32'd0);
      chk("flush_empty", 32'(fifoEmpty), 32'd1);
      chk("flush_overrun", 32'(overrun), 32'd1);
      step(1, 0, 8'h22, 3'd1);
      reset = 1'b0;
      step(1, 0, 8'h33, 3'd0);
      reset = 1'b1;
      chk("reset_entries", 32'(nrOfEntries), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      chk("reset_err", 32'(errorPresent), 32'd0);

      // random traffic in bursts of write-heavy, read-heavy, balanced and idle phases
      mode = 0;
      for (int c = 0; c < 3000; c++) begin
         bit we, re;
         if (c % 64 == 0) begin
            mode = $urandom_range(0, 3);
            triggerLevel = 5'($urandom_range(0, 17));
         end
         case (mode)
            0: begin we = ($urandom_range(0, 9) < 8); re = ($urandom_range(0, 9) < 2); end
            1: begin we = ($urandom_range(0, 9) < 2); re = ($urandom_range(0, 9) < 8); end
            2: begin we = $urandom_range(0, 1); re = $urandom_range(0, 1); end
            default: begin we = 1'b0; re = 1'b0; end
         endcase
         flush        = ($urandom_range(0, 149) == 0);
         clearOverrun = !flush && ($urandom_range(0, 19) == 0);
         reset        = ($urandom_range(0, 699) != 0);
         step(we, re, 8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
      end
      flush = 1'b0;
      clearOverrun = 1'b0;
      reset = 1'b1;
      step(0, 0, 8'h00, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
